// File: rtl/uart_tx_serializer.sv
// Byte-wide 8N1 UART transmitter with a one-cycle done pulse for the upstream LSU.
// Optional even-parity bit compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start_n,
  input  logic [7:0] tx_data,
  output logic       tx_out,
  output logic       tx_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       shift, shift_d;
  logic             tx_out_d, tx_done_d, busy_d;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             par, par_d;
`endif

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      tx_out  <= 1'b1;
      tx_done <= 1'b0;
      busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      idx     <= idx_d;
      shift   <= shift_d;
      tx_out  <= tx_out_d;
      tx_done <= tx_done_d;
      busy    <= busy_d;
`ifdef UART_TX_PARITY_EN
      par     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shift_d = shift;
`ifdef UART_TX_PARITY_EN
    par_d   = par;
`endif

    case (state)
      IDLE: begin
        if (!tx_start_n) begin
          state_d = START;
          shift_d = tx_data;
          cnt_d   = '0;
          idx_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      START: begin
        cnt_d = bit_end ? '0 : cnt + CNT_W'(1);
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        cnt_d = bit_end ? '0 : cnt + CNT_W'(1);
        if (bit_end) begin
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            shift_d = shift >> 1;
            idx_d   = idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        cnt_d = bit_end ? '0 : cnt + CNT_W'(1);
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        cnt_d = bit_end ? '0 : cnt + CNT_W'(1);
        if (bit_end) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every one of them leaves a flop.
  always_comb begin
    tx_out_d  = 1'b1;
    tx_done_d = (state_d == DONE);
    busy_d    = (state_d != IDLE);
    case (state_d)
      START:  tx_out_d = 1'b0;
      DATA:   tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_out_d = par_d;
`endif
      default: tx_out_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer at CLKS_PER_BIT=4; a line monitor
// rebuilds each expected frame from the queued byte and checks it cycle by cycle.
module tb_uart_tx_serializer;

  localparam int unsigned C  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start_n = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_out, tx_done, busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [7:0]  q[$];
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned last_done_cyc = 0;
  int unsigned gap_cyc = 0;
  int unsigned pos = 0;
  bit          in_frame = 0;
  bit          post_done = 0;
  logic [10:0] frame = '1;

  uart_tx_serializer #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_start_n (tx_start_n),
    .tx_data    (tx_data),
    .tx_out     (tx_out),
    .tx_done    (tx_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line monitor: frame bits are LSB first, start 0, optional even parity, stop 1.
  always @(negedge clk) begin
    cyc++;
    if (reset && tx_done) done_cnt++;
    if (!reset) begin
      in_frame  = 0;
      post_done = 0;
    end else begin
      if (post_done) begin
        check("idle_done", tx_done, 0);
        check("idle_busy", busy, 0);
        check("idle_line", tx_out, 1);
        post_done = 0;
      end else if (!in_frame && tx_out == 1'b0) begin
        if (q.size() == 0) begin
          check("sb_nonempty", q.size(), 1);
        end else begin
          frame      = '1;
          frame[0]   = 1'b0;
          frame[8:1] = q[0];
`ifdef UART_TX_PARITY_EN
          frame[9]   = ^q[0];
`endif
          gap_cyc  = cyc - last_done_cyc;
          in_frame = 1;
          pos      = 0;
        end
      end else if (!in_frame) begin
        check("stray_done", tx_done, 0);
      end

      if (in_frame) begin
        if (pos < NB * C) begin
          check("line", tx_out, frame[pos / C]);
          check("busy", busy, 1);
          check("early_done", tx_done, 0);
          pos++;
        end else begin
          check("done_pulse", tx_done, 1);
          check("done_line", tx_out, 1);
          check("done_busy", busy, 1);
          last_done_cyc = cyc;
          in_frame  = 0;
          post_done = 1;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", busy, 0);
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_done !== 1'b1 && n < 2000);
    if (n >= 2000) check("done_timeout", tx_done, 1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_idle();
    @(negedge clk);
    tx_data    = b;
    tx_start_n = 1'b0;
    q.push_back(b);
    @(negedge clk);
    check("accept_busy", busy, 1);
    check("accept_fall", tx_out, 0);
    tx_start_n = 1'b1;
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    check("rst0_line", tx_out, 1);
    check("rst0_done", tx_done, 0);
    check("rst0_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset while idle, away from any clock edge.
    #2 reset = 1'b0;
    #1;
    check("rst_line", tx_out, 1);
    check("rst_done", tx_done, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame; the monitor checks every cycle and the done position.
    send(8'hA5);
    wait_idle();
    repeat (3) @(negedge clk);

    // LSU-style: request held low, data switched during the done cycle.
    @(negedge clk);
    tx_data    = 8'h01;
    tx_start_n = 1'b0;
    q.push_back(8'h01);
    q.push_back(8'h3C);
    wait_done();
    tx_data = 8'h3C;
    wait_done();
    tx_start_n = 1'b1;
    check("b2b_gap", gap_cyc, 2);
    wait_idle();
    repeat (4) @(negedge clk);
    check("b2b_done_cnt", done_cnt, 3);

    // Inputs ignored mid-frame.
    send(8'h5A);
    repeat (12) @(negedge clk);
    tx_data    = 8'hFF;
    tx_start_n = 1'b0;
    repeat (5) @(negedge clk);
    tx_start_n = 1'b1;
    repeat (3) @(negedge clk);
    tx_start_n = 1'b0;
    repeat (2) @(negedge clk);
    tx_start_n = 1'b1;
    wait_idle();
    repeat (4) @(negedge clk);
    check("mid_done_cnt", done_cnt, 4);

    // Reset during DATA bit 3 (cycles 16..19 after acceptance) abandons the frame.
    send(8'hC3);
    repeat (17) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_line", tx_out, 1);
    check("abort_done", tx_done, 0);
    check("abort_busy", busy, 0);
    q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_done", done_cnt, 4);

    send(8'h81);
    wait_idle();
    repeat (4) @(negedge clk);

    check("total_done", done_cnt, 5);
    check("sb_left", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before t=200000");
    $fatal(1);
  end

endmodule
